// File: rtl/dds_wave_gen_if.sv
// Configuration channel for dds_wave_gen: one valid/ready transfer carries
// a complete waveform setting (mode, frequency, phase, duty, amplitude, burst).
interface dds_wave_gen_if #(
   parameter int ACC_W   = 32,
   parameter int AMP_W   = 8,
   parameter int BURST_W = 16
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [1:0]         cfg_mode;
   logic [ACC_W-1:0]   cfg_fword;
   logic [ACC_W-1:0]   cfg_poff;
   logic [ACC_W-1:0]   cfg_duty;
   logic [AMP_W-1:0]   cfg_amp;
   logic [BURST_W-1:0] cfg_burst;

   modport master (
      output cfg_valid, cfg_mode, cfg_fword, cfg_poff, cfg_duty, cfg_amp, cfg_burst,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_mode, cfg_fword, cfg_poff, cfg_duty, cfg_amp, cfg_burst,
      output cfg_ready
   );
endinterface

// File: rtl/dds_wave_gen.sv
// Phase-accumulator waveform source (sine via external ROM, square, triangle,
// sawtooth) with amplitude scaling, burst count and wrap-aligned config updates.
module dds_wave_gen #(
   parameter int ACC_W   = 32,
   parameter int DATA_W  = 8,
   parameter int LUT_AW  = 10,
   parameter int AMP_W   = 8,
   parameter int BURST_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   dds_wave_gen_if.slave      cfg,
   input  logic               run,
   output logic [LUT_AW-1:0]  rom_addr,
   input  logic [DATA_W-1:0]  rom_data,
   output logic [DATA_W-1:0]  data_out,
   output logic               data_valid,
   output logic               cyc_sync,
   output logic               busy
);
   localparam int PROD_W = DATA_W + AMP_W + 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   typedef struct packed {
      logic [1:0]         mode;
      logic [ACC_W-1:0]   fword;
      logic [ACC_W-1:0]   poff;
      logic [ACC_W-1:0]   duty;
      logic [AMP_W-1:0]   amp;
      logic [BURST_W-1:0] burst;
   } cfg_t;

   state_t             state_r;
   cfg_t               shadow_r, active_r, offer_s;
   logic               pending_r, cfg_ready_r, busy_r, cyc_sync_r, done_r;
   logic [ACC_W-1:0]   acc_r, phase_s;
   logic [BURST_W-1:0] burst_cnt_r;
   logic [ACC_W:0]     sum_s;
   logic               take_s, wrap_s, fword_zero_s, burst_end_s, stop_s, apply_s;

   logic [ACC_W-1:0]   phase_r, duty0_r;
   logic [1:0]         mode0_r, mode1_r;
   logic [AMP_W-1:0]   amp0_r, amp1_r;
   logic [AMP_W:0]     amp_p1_s;
   logic               v1_r, v2_r, data_valid_r;
   logic [LUT_AW-1:0]  rom_addr_r;
   logic [DATA_W-1:0]  w_s, w_r, sample_s, data_out_r;
   logic [PROD_W-1:0]  prod_s;

   // Handshake, wrap detection and the stop/apply decisions for this cycle.
   always_comb begin
      offer_s      = {cfg.cfg_mode, cfg.cfg_fword, cfg.cfg_poff, cfg.cfg_duty,
                      cfg.cfg_amp, cfg.cfg_burst};
      sum_s        = {1'b0, acc_r} + {1'b0, active_r.fword};
      take_s       = cfg.cfg_valid & cfg_ready_r;
      wrap_s       = (state_r == RUN) & sum_s[ACC_W];
      fword_zero_s = (active_r.fword == {ACC_W{1'b0}});
      burst_end_s  = (active_r.burst != {BURST_W{1'b0}}) &&
                     (burst_cnt_r == (active_r.burst - {{(BURST_W-1){1'b0}}, 1'b1}));
      stop_s       = (wrap_s & (~run | burst_end_s)) | (fword_zero_s & ~run);
      apply_s      = pending_r & ((state_r == IDLE) | wrap_s | fword_zero_s);
      phase_s      = acc_r + active_r.poff;
   end

   // Config shadow/active registers and the IDLE/RUN sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         shadow_r    <= '0;
         active_r    <= '0;
         pending_r   <= 1'b0;
         cfg_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         cyc_sync_r  <= 1'b0;
         done_r      <= 1'b0;
         acc_r       <= {ACC_W{1'b0}};
         burst_cnt_r <= {BURST_W{1'b0}};
      end else begin
         if (take_s) begin
            shadow_r    <= offer_s;
            pending_r   <= 1'b1;
            cfg_ready_r <= 1'b0;
         end else if (apply_s) begin
            active_r    <= shadow_r;
            pending_r   <= 1'b0;
            cfg_ready_r <= 1'b1;
         end else begin
            pending_r   <= pending_r;
         end
         cyc_sync_r <= wrap_s;
         case (state_r)
            IDLE: begin
               // A finished burst waits for run to drop or a fresh config.
               if (!run || pending_r) begin
                  done_r <= 1'b0;
               end
               if (run && !pending_r && !done_r) begin
                  state_r     <= RUN;
                  busy_r      <= 1'b1;
                  acc_r       <= {ACC_W{1'b0}};
                  burst_cnt_r <= {BURST_W{1'b0}};
               end
            end
            RUN: begin
               acc_r <= sum_s[ACC_W-1:0];
               if (wrap_s) begin
                  burst_cnt_r <= burst_cnt_r + {{(BURST_W-1){1'b0}}, 1'b1};
               end
               if (stop_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= wrap_s & burst_end_s;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Waveform computed from the registered phase, using the duty carried with it.
   always_comb begin
      case (mode0_r)
         2'd1:    w_s = (phase_r < duty0_r) ? {DATA_W{1'b0}} : {DATA_W{1'b1}};
         2'd2:    w_s = phase_r[ACC_W-1] ? ~phase_r[ACC_W-2 -: DATA_W]
                                         :  phase_r[ACC_W-2 -: DATA_W];
         default: w_s = phase_r[ACC_W-1 -: DATA_W];
      endcase
   end

   // Sample select and full-width amplitude product.
   always_comb begin
      if (mode1_r == 2'd0) begin
         sample_s = rom_data;
      end else begin
         sample_s = w_r;
      end
      amp_p1_s = {1'b0, amp1_r} + {{AMP_W{1'b0}}, 1'b1};
      prod_s   = {{(AMP_W+1){1'b0}}, sample_s} * {{DATA_W{1'b0}}, amp_p1_s};
   end

   // Three-stage sample pipeline; rom_addr leaves with the phase so ROM data
   // lines up with the registered waveform one clock later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_r      <= {ACC_W{1'b0}};
         duty0_r      <= {ACC_W{1'b0}};
         mode0_r      <= 2'd0;
         amp0_r       <= {AMP_W{1'b0}};
         v1_r         <= 1'b0;
         rom_addr_r   <= {LUT_AW{1'b0}};
         w_r          <= {DATA_W{1'b0}};
         mode1_r      <= 2'd0;
         amp1_r       <= {AMP_W{1'b0}};
         v2_r         <= 1'b0;
         data_out_r   <= {DATA_W{1'b0}};
         data_valid_r <= 1'b0;
      end else begin
         phase_r      <= phase_s;
         duty0_r      <= active_r.duty;
         mode0_r      <= active_r.mode;
         amp0_r       <= active_r.amp;
         v1_r         <= busy_r;
         rom_addr_r   <= phase_s[ACC_W-1 -: LUT_AW];
         w_r          <= w_s;
         mode1_r      <= mode0_r;
         amp1_r       <= amp0_r;
         v2_r         <= v1_r;
         data_out_r   <= v2_r ? prod_s[AMP_W +: DATA_W] : {DATA_W{1'b0}};
         data_valid_r <= v2_r;
      end
   end

   assign cfg.cfg_ready = cfg_ready_r;
   assign rom_addr      = rom_addr_r;
   assign data_out      = data_out_r;
   assign data_valid    = data_valid_r;
   assign cyc_sync      = cyc_sync_r;
   assign busy          = busy_r;
endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed self-checking bench for dds_wave_gen with a registered sine-ROM stand-in.
module tb_dds_wave_gen;
   localparam int ACC_W = 32, DATA_W = 8, LUT_AW = 10, AMP_W = 8, BURST_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   logic [LUT_AW-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data = 8'h00;
   logic [DATA_W-1:0] data_out;
   logic data_valid, cyc_sync, busy;
   int n_checks = 0;
   int n_fail = 0;

   dds_wave_gen_if #(.ACC_W(ACC_W), .AMP_W(AMP_W), .BURST_W(BURST_W)) cfg_bus ();

   dds_wave_gen #(.ACC_W(ACC_W), .DATA_W(DATA_W), .LUT_AW(LUT_AW), .AMP_W(AMP_W),
                  .BURST_W(BURST_W)) dut (
      .clk(clk), .rst(rst), .cfg(cfg_bus), .run(run), .rom_addr(rom_addr),
      .rom_data(rom_data), .data_out(data_out), .data_valid(data_valid),
      .cyc_sync(cyc_sync), .busy(busy)
   );

   always #5 clk = ~clk;

   // ROM content is address-derived so misalignment shows up as a wrong value.
   always @(posedge clk) rom_data <= rom_addr[9:2] ^ 8'hA5;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_cfg(input logic [1:0] m, input logic [31:0] fw, input logic [31:0] po,
                           input logic [31:0] du, input logic [7:0] am, input logic [15:0] bu);
      int guard = 0;
      cfg_bus.cfg_mode = m;  cfg_bus.cfg_fword = fw; cfg_bus.cfg_poff = po;
      cfg_bus.cfg_duty = du; cfg_bus.cfg_amp = am;   cfg_bus.cfg_burst = bu;
      cfg_bus.cfg_valid = 1'b1;
      while (cfg_bus.cfg_ready !== 1'b1 && guard < 200) begin
         tick();
         guard++;
      end
      n_checks++;
      if (cfg_bus.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_accept: cfg_ready=%0b required 1", cfg_bus.cfg_ready);
      end
      tick();
      cfg_bus.cfg_valid = 1'b0;
   endtask

   task automatic start_run(output int t_busy, output int t_valid);
      t_busy = 0;
      t_valid = 0;
      run = 1'b1;
      while (busy !== 1'b1 && t_busy < 50) begin
         tick();
         t_busy++;
      end
      while (data_valid !== 1'b1 && t_valid < 50) begin
         tick();
         t_valid++;
      end
   endtask

   task automatic stop_drain();
      int g = 0;
      run = 1'b0;
      while (busy !== 1'b0 && g < 200) begin
         tick();
         g++;
      end
      tick(4);
   endtask

   task automatic test_reset();
      tick(3);
      n_checks++;
      if ({data_out, data_valid, cyc_sync, busy, cfg_bus.cfg_ready, rom_addr} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000}) begin
         n_fail++;
         $display("FAIL reset_values: got dout=%0h dv=%0b sync=%0b busy=%0b rdy=%0b addr=%0h required 0,0,0,0,1,0",
                  data_out, data_valid, cyc_sync, busy, cfg_bus.cfg_ready, rom_addr);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_saw();
      int tbz, tv;
      logic [7:0] exp_d;
      send_cfg(2'd3, 32'h1000_0000, 32'h0, 32'h0, 8'hFF, 16'd0);
      n_checks++;
      if (cfg_bus.cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL saw_ready_low: got %0b required 0", cfg_bus.cfg_ready);
      end
      tick();
      n_checks++;
      if (cfg_bus.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL saw_ready_back: got %0b required 1", cfg_bus.cfg_ready);
      end
      start_run(tbz, tv);
      n_checks++;
      if (tbz !== 1 || tv !== 3) begin
         n_fail++;
         $display("FAIL saw_latency: got busy_after=%0d valid_after=%0d required 1 and 3", tbz, tv);
      end
      for (int i = 0; i < 48; i++) begin
         exp_d = 8'(i * 16);
         n_checks++;
         if (data_valid !== 1'b1 || data_out !== exp_d) begin
            n_fail++;
            $display("FAIL saw_sample[%0d]: got %0h (dv=%0b) required %0h", i, data_out, data_valid, exp_d);
         end
         n_checks++;
         if (cyc_sync !== ((i % 16) == 13)) begin
            n_fail++;
            $display("FAIL saw_sync[%0d]: got %0b required %0b", i, cyc_sync, ((i % 16) == 13));
         end
         tick();
      end
      stop_drain();
      n_checks++;
      if ({busy, data_valid, data_out} !== {1'b0, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL saw_drain: got busy=%0b dv=%0b dout=%0h required 0,0,0", busy, data_valid, data_out);
      end
   endtask

   task automatic test_square();
      int tbz, tv;
      logic [7:0] exp_d;
      send_cfg(2'd1, 32'h1000_0000, 32'h0, 32'h4000_0000, 8'hFF, 16'd0);
      start_run(tbz, tv);
      for (int i = 0; i < 32; i++) begin
         exp_d = ((i % 16) < 4) ? 8'h00 : 8'hFF;
         n_checks++;
         if (data_valid !== 1'b1 || data_out !== exp_d) begin
            n_fail++;
            $display("FAIL square[%0d]: got %0h (dv=%0b) required %0h", i, data_out, data_valid, exp_d);
         end
         tick();
      end
      stop_drain();
   endtask

   task automatic test_triangle();
      int tbz, tv, k, tri_v;
      logic [7:0] exp_d;
      send_cfg(2'd2, 32'h1000_0000, 32'h0, 32'h0, 8'h7F, 16'd0);
      start_run(tbz, tv);
      for (int i = 0; i < 16; i++) begin
         k = i % 16;
         tri_v = (k < 8) ? (k % 8) * 32 : 255 - (k % 8) * 32;
         exp_d = 8'((tri_v * 128) >> 8);
         n_checks++;
         if (data_valid !== 1'b1 || data_out !== exp_d) begin
            n_fail++;
            $display("FAIL triangle[%0d]: got %0h (dv=%0b) required %0h", i, data_out, data_valid, exp_d);
         end
         if (i == 8) begin
            n_checks++;
            if (data_out !== 8'h7F) begin
               n_fail++;
               $display("FAIL triangle_peak: got %0h required 7f", data_out);
            end
         end
         tick();
      end
      stop_drain();
   endtask

   task automatic test_sine();
      int tbz, tv;
      logic [7:0] exp_d;
      send_cfg(2'd0, 32'h1000_0000, 32'h0800_0000, 32'h0, 8'hFF, 16'd0);
      start_run(tbz, tv);
      for (int i = 0; i < 16; i++) begin
         exp_d = 8'(i * 16 + 8) ^ 8'hA5;
         n_checks++;
         if (data_valid !== 1'b1 || data_out !== exp_d) begin
            n_fail++;
            $display("FAIL sine_rom[%0d]: got %0h (dv=%0b) required %0h", i, data_out, data_valid, exp_d);
         end
         tick();
      end
      stop_drain();
   endtask

   task automatic test_burst();
      int nv = 0, nc = 0, nb = 0;
      send_cfg(2'd3, 32'h1000_0000, 32'h0, 32'h0, 8'hFF, 16'd3);
      run = 1'b1;
      for (int c = 0; c < 120; c++) begin
         tick();
         if (busy === 1'b1) nb++;
         if (cyc_sync === 1'b1) nc++;
         if (data_valid === 1'b1) begin
            n_checks++;
            if (data_out !== 8'(nv * 16)) begin
               n_fail++;
               $display("FAIL burst_sample[%0d]: got %0h required %0h", nv, data_out, 8'(nv * 16));
            end
            nv++;
         end
      end
      n_checks++;
      if (nv !== 48 || nc !== 3 || nb !== 48) begin
         n_fail++;
         $display("FAIL burst_counts: got valid=%0d sync=%0d busy=%0d required 48,3,48", nv, nc, nb);
      end
      n_checks++;
      if ({busy, data_valid, data_out} !== {1'b0, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL burst_idle: got busy=%0b dv=%0b dout=%0h required 0,0,0", busy, data_valid, data_out);
      end
      run = 1'b0;
      tick(2);
   endtask

   task automatic test_midrun_cfg();
      int tbz, tv;
      logic [7:0] exp_d;
      logic exp_rdy, exp_sync;
      send_cfg(2'd3, 32'h1000_0000, 32'h0, 32'h0, 8'hFF, 16'd0);
      start_run(tbz, tv);
      for (int i = 0; i < 56; i++) begin
         exp_d = (i < 16) ? 8'(i * 16) : 8'((i - 16) * 8);
         exp_sync = (i == 13) || (i == 45);
         exp_rdy = !((i >= 6) && (i <= 12));
         n_checks++;
         if (data_valid !== 1'b1 || data_out !== exp_d) begin
            n_fail++;
            $display("FAIL midrun_sample[%0d]: got %0h (dv=%0b) required %0h", i, data_out, data_valid, exp_d);
         end
         n_checks++;
         if (cyc_sync !== exp_sync) begin
            n_fail++;
            $display("FAIL midrun_sync[%0d]: got %0b required %0b", i, cyc_sync, exp_sync);
         end
         if (i <= 20) begin
            n_checks++;
            if (cfg_bus.cfg_ready !== exp_rdy) begin
               n_fail++;
               $display("FAIL midrun_ready[%0d]: got %0b required %0b", i, cfg_bus.cfg_ready, exp_rdy);
            end
         end
         if (i == 5) begin
            cfg_bus.cfg_fword = 32'h0800_0000;
            cfg_bus.cfg_valid = 1'b1;
         end else begin
            cfg_bus.cfg_valid = 1'b0;
         end
         tick();
      end
      stop_drain();
   endtask

   task automatic test_run_stop();
      int tbz, tv, nv = 0;
      send_cfg(2'd3, 32'h1000_0000, 32'h0, 32'h0, 8'hFF, 16'd0);
      start_run(tbz, tv);
      for (int c = 0; c < 40; c++) begin
         if (data_valid === 1'b1) begin
            n_checks++;
            if (data_out !== 8'(nv * 16)) begin
               n_fail++;
               $display("FAIL runstop_sample[%0d]: got %0h required %0h", nv, data_out, 8'(nv * 16));
            end
            nv++;
         end
         if (c == 7) run = 1'b0;
         tick();
      end
      n_checks++;
      if (nv !== 16 || busy !== 1'b0 || data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL runstop_end: got samples=%0d busy=%0b dout=%0h required 16,0,0", nv, busy, data_out);
      end
   endtask

   task automatic test_reset_mid();
      int tbz, tv;
      send_cfg(2'd3, 32'h1000_0000, 32'h0, 32'h0, 8'hFF, 16'd0);
      start_run(tbz, tv);
      cfg_bus.cfg_mode = 2'd1;
      cfg_bus.cfg_valid = 1'b1;
      tick();
      cfg_bus.cfg_valid = 1'b0;
      tick(2);
      n_checks++;
      if (cfg_bus.cfg_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_pre: got rdy=%0b busy=%0b required 0,1", cfg_bus.cfg_ready, busy);
      end
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({data_out, data_valid, cyc_sync, busy, cfg_bus.cfg_ready, rom_addr} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000}) begin
         n_fail++;
         $display("FAIL rstmid_values: got dout=%0h dv=%0b sync=%0b busy=%0b rdy=%0b addr=%0h required 0,0,0,0,1,0",
                  data_out, data_valid, cyc_sync, busy, cfg_bus.cfg_ready, rom_addr);
      end
      run = 1'b0;
      rst = 1'b0;
      tick(2);
      run = 1'b1;
      tick(8);
      n_checks++;
      if ({busy, data_valid, data_out, rom_addr, cfg_bus.cfg_ready} !== {1'b1, 1'b1, 8'h00, 10'h000, 1'b1}) begin
         n_fail++;
         $display("FAIL rstmid_discard: got busy=%0b dv=%0b dout=%0h addr=%0h rdy=%0b required 1,1,0,0,1",
                  busy, data_valid, data_out, rom_addr, cfg_bus.cfg_ready);
      end
      run = 1'b0;
      tick(5);
      n_checks++;
      if ({busy, data_valid} !== {1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rstmid_zero_fword_stop: got busy=%0b dv=%0b required 0,0", busy, data_valid);
      end
   endtask

   initial begin
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_mode  = 2'd0;
      cfg_bus.cfg_fword = 32'h0;
      cfg_bus.cfg_poff  = 32'h0;
      cfg_bus.cfg_duty  = 32'h0;
      cfg_bus.cfg_amp   = 8'h00;
      cfg_bus.cfg_burst = 16'd0;
      test_reset();
      test_saw();
      test_square();
      test_triangle();
      test_sine();
      test_burst();
      test_midrun_cfg();
      test_run_stop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
- Parametrised successor to the fixed-table signal generator.
- Phase-accumulator (DDS) source producing sine, square, triangle and sawtooth samples for the DA path.
- Adds arbitrary frequency/phase words, a true duty threshold, multiplicative amplitude, burst count, and glitch-free config updates at cycle boundaries.
- Sine comes from an external registered ROM; the other waveforms are computed from phase.

Parameters:
ACC_W, 32, phase accumulator / frequency word / phase offset / duty width
DATA_W, 8, sample width
LUT_AW, 10, sine ROM address width (full-cycle table, 2^LUT_AW entries)
AMP_W, 8, amplitude scale width
BURST_W, 16, burst cycle counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config offer
cfg_ready  out  1  config slot free
cfg_mode  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
cfg_fword  in  ACC_W  phase increment per clk
cfg_poff  in  ACC_W  phase offset
cfg_duty  in  ACC_W  square low-phase threshold
cfg_amp  in  AMP_W  amplitude scale; all-ones = unity
cfg_burst  in  BURST_W  cycles per burst; 0 = continuous
run  in  1  level: start/continue generation
rom_addr  out  LUT_AW  sine ROM address
rom_data  in  DATA_W  sine ROM data, valid 1 clk after rom_addr
data_out  out  DATA_W  sample
data_valid  out  1  data_out valid
cyc_sync  out  1  1-clk pulse on each accumulator wrap
busy  out  1  high in RUN

Behaviour:
- Reset values: data_out=0, data_valid=0, cyc_sync=0, busy=0, cfg_ready=1, rom_addr=0, acc=0, pending=0. Active config is all zero (mode sine, fword 0, amp 0, burst 0).
- Config handshake:
  - Transfer when cfg_valid & cfg_ready. All cfg_* fields are captured into a shadow register and pending is set.
  - cfg_ready = !pending, registered. It goes low the cycle after acceptance.
- Shadow→active apply:
  - In IDLE: the cycle after capture.
  - In RUN: on the cycle the accumulator wraps (carry out of acc+fword).
  - In RUN with active fword==0: next cycle.
  - Pending clears on apply; cfg_ready returns high the following cycle.
- FSM IDLE→RUN:
  - Condition: run=1 and pending=0, or run=1 in the cycle after an IDLE apply.
  - On entry: acc=0, burst_cnt=0.
- FSM RUN:
  - acc <= acc + fword each clk, mod 2^ACC_W.
  - On wrap: cyc_sync=1 and burst_cnt++.
- FSM RUN→IDLE:
  - At a wrap when run=0 (finish the current cycle).
  - At a wrap when burst≠0 and burst_cnt==burst-1.
  - Immediately when fword==0 and run=0.
  - A pending config applied at that same wrap takes effect. The next run starts with it.
- Pipeline (total latency 3 clk from acc to data_out; data_valid tracks busy delayed 3 clk):
  - S0: phase = acc + poff.
  - S1: rom_addr = phase[ACC_W-1 -: LUT_AW]. The computed waveform w is registered alongside.
  - S2: select sample s (rom_data for sine, else w), then data_out = (s*(amp+1)) >> AMP_W. The product uses full width DATA_W+AMP_W+1 and is truncated, never saturated.
- Waveforms (phase p, top bits t = p[ACC_W-1 -: DATA_W]):
  - saw = t.
  - tri = p[ACC_W-1] ? ~p[ACC_W-2 -: DATA_W] : p[ACC_W-2 -: DATA_W].
  - square = (p < duty) ? 0 : all-ones. With duty=0 the output is always high.
- Mode is carried down the pipeline with its sample, so a mode change never mixes mode/sample.
- data_out is forced 0 whenever data_valid=0.
- Async rst mid-operation: immediate return to reset values. Pending config is discarded.

Test Plan:
- Reset then config {saw, fword=2^28, poff=0, amp=0xFF, burst=0}, run=1 (AMP_W=DATA_W=8, ACC_W=32) -> data_valid rises 3 clk after busy; data_out 0x00,0x10,...,0xF0 repeating; cyc_sync every 16 clk.
- Square, duty=0x4000_0000, fword=2^28 -> per 16-sample cycle 4 samples of 0x00 then 12 of 0xFF.
- Triangle, amp=0x7F -> samples of full-scale triangle halved (peak 0x7F); tri at p=0x8000_0000 gives 0x7F after scaling.
- Burst=3, run held high -> exactly 48 valid samples, 3 cyc_sync pulses, busy falls at third wrap, data_out=0 after drain.
- Mid-run config fword 2^28→2^27 offered at sample 5 -> cfg_ready low until the wrap at sample 16; period becomes 32 from the next cycle; no partial cycle.
- run deasserted at sample 7 -> generation continues to wrap (sample 16), then IDLE; assert rst at sample 3 of another run -> all outputs 0 next edge, cfg_ready=1.
